instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Writer-side counterpart of the main decoder: accepts structured instruction requests (kind, registers, immediate) over a valid/ready handshake, encodes each into a 32-bit RV32I word using the same opcode set the decoder recognises, and writes it into instruction memory at an auto-incrementing word address. It serves as the boot/test program loader ahead of the single-cycle core's instruction memory.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset/start; must be < 2^ADDR_W
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous restart pulse
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_kind  in  3  0 LW, 1 SW, 2 R-type, 3 BEQ, 4 I-type ALU, 5 JAL, 6–7 illegal
- req_funct3  in  3  funct3 for R-type / I-type ALU (ignored otherwise)
- req_funct7b5  in  1  instr bit 30 for R-type (ignored otherwise)
- req_rd, req_rs1, req_rs2  in  5 each  register fields
- req_imm  in  21  signed byte offset/immediate, two's complement
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  memory region exhausted
- err  out  1  sticky: an illegal request was dropped

## Operation
- Opcodes: LW 0000011 (funct3 010), SW 0100011 (funct3 010), R 0110011, BEQ 1100011 (funct3 000), I-ALU 0010011, JAL 1101111.
- Formats: I (LW, I-ALU) = imm[11:0]|rs1|f3|rd|op; R = 0,f7b5,00000|rs2|rs1|f3|rd|op; S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. I-ALU bit 30 comes only from imm[10].
- Legality: I/S need req_imm[20:11] all equal; B needs req_imm[20:12] all equal and imm[0]=0; J needs imm[0]=0; kind 6/7 illegal. Illegal request: accepted (handshake completes), no write, pointer/count unchanged, err←1.
- FSM: IDLE (req_ready=1) → on legal handshake latch encoded word → WRITE; illegal handshake stays IDLE. WRITE (req_ready=0, imem_we=1 with imem_addr=pointer) → pointer+1, count+1; if pointer was 2^ADDR_W−1 → FULL, else IDLE. FULL: req_ready=0, full=1, holds until start.
- start (any state, priority over handshake): pointer←BASE_ADDR, count←0, full←0, err←0, state←IDLE; req_ready forced 0 while start=1. start in WRITE: the write in that cycle still occurs at the old pointer, then reset values apply.
- Capacity: 2^ADDR_W − BASE_ADDR words; pointer never wraps.

## Timing
- Reset (rst_n low, immediate): state IDLE, pointer BASE_ADDR, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, count 0, full 0, err 0; req_ready 0 while rst_n low, 1 from first cycle after release.
- Latency: handshake at edge N → imem_we=1 during cycle N+1 → next handshake earliest at edge N+2. Throughput one word per 2 cycles.
- imem_addr/imem_wdata registered, stable for the whole imem_we cycle; imem_we never high two consecutive cycles.
- err/full update at the edge ending the causing cycle; reset mid-WRITE drops imem_we asynchronously, no partial write.

## Test plan
- LW rd=5 rs1=2 imm=8 after reset → one cycle later imem_we=1, addr 0, wdata 0x00812283, count=1.
- R-type f3=000 f7b5=1 rd=3 rs1=1 rs2=2 → wdata 0x402081B3 at next address.
- BEQ rs1=1 rs2=2 imm=−4 → 0xFE208EE3; JAL rd=1 imm=8 → 0x008000EF, consecutive addresses.
- BEQ imm=3, then kind=6 → both accepted, no imem_we, err=1, count unchanged; following SW rs1=2 rs2=5 imm=12 → 0x00512623 written at the un-advanced address.
- ADDR_W=2, BASE_ADDR=0: four legal requests → addrs 0..3, full=1, req_ready=0; start pulse → full=0, err=0, count=0, next write addr 0.
- rst_n low during WRITE cycle → imem_we falls immediately, all outputs at reset values, no further writes.

Source files
------------

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Purpose  : Encodes structured instruction requests into RV32I words and
//            writes them to instruction memory at an auto-incrementing
//            word address (boot/test program loader).
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [20:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] C_BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_PTR_MAX  = '1;
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W+1)'(1);

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_REG    = 7'b0110011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       w_enc_word;
  logic              w_enc_legal;
  logic              w_imm12_ok;
  logic              w_imm13_ok;

  // Immediate range checks: upper bits must be pure sign extension.
  assign w_imm12_ok = (&req_imm[20:11]) | ~(|req_imm[20:11]);
  assign w_imm13_ok = (&req_imm[20:12]) | ~(|req_imm[20:12]);

  // Encode the request into an RV32I word and decide whether it is legal.
  always_comb begin
    w_enc_word  = 32'h0;
    w_enc_legal = 1'b0;
    case (req_kind)
      3'd0: begin
        w_enc_word  = {req_imm[11:0], req_rs1, 3'b010, req_rd, C_OP_LOAD};
        w_enc_legal = w_imm12_ok;
      end
      3'd1: begin
        w_enc_word  = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], C_OP_STORE};
        w_enc_legal = w_imm12_ok;
      end
      3'd2: begin
        w_enc_word  = {1'b0, req_funct7b5, 5'b00000, req_rs2, req_rs1, req_funct3, req_rd, C_OP_REG};
        w_enc_legal = 1'b1;
      end
      3'd3: begin
        w_enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                       req_imm[4:1], req_imm[11], C_OP_BRANCH};
        w_enc_legal = w_imm13_ok & ~req_imm[0];
      end
      3'd4: begin
        // Bit 30 is taken from the immediate only; funct7b5 is not merged in.
        w_enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, C_OP_IMM};
        w_enc_legal = w_imm12_ok;
      end
      3'd5: begin
        w_enc_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, C_OP_JAL};
        w_enc_legal = ~req_imm[0];
      end
      default: begin
        w_enc_word  = 32'h0;
        w_enc_legal = 1'b0;
      end
    endcase
  end

  // Ready only in IDLE, never while start is asserted or reset is active.
  assign req_ready = rst_n & (state_q == S_IDLE) & ~start;

  // Next-state logic: accept/latch in IDLE, commit a write in WRITE, park in FULL.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (w_enc_legal) begin
            wdata_d = w_enc_word;
            state_d = S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + C_CNT_ONE;
        if (ptr_q == C_PTR_MAX) begin
          // Last word of the region: pointer holds, no wrap.
          state_d = S_FULL;
        end else begin
          ptr_d   = ptr_q + C_PTR_ONE;
          state_d = S_IDLE;
        end
      end
      S_FULL: begin
        state_d = S_FULL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Restart wins over everything; a write in progress has already been
    // presented this cycle, so only the bookkeeping is discarded.
    if (start) begin
      state_d = S_IDLE;
      ptr_d   = C_BASE_PTR;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= C_BASE_PTR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // Write strobe follows the registered state, so reset removes it at once.
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign count      = cnt_q;
  assign full       = (state_q == S_FULL);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Purpose  : Directed self-checking bench for instr_encoder_loader
//            (ADDR_W=2, BASE_ADDR=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [2:0]        req_funct3;
  logic              req_funct7b5;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [20:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int n_checks;
  int n_fail;
  int wr_cnt;
  int b2b_cnt;
  logic last_we;

  instr_encoder_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_funct3   (req_funct3),
    .req_funct7b5 (req_funct7b5),
    .req_rd       (req_rd),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_imm      (req_imm),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .count        (count),
    .full         (full),
    .err          (err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes and flag any back-to-back strobe.
  always @(negedge clk) begin
    if (imem_we) wr_cnt++;
    if (imem_we && last_we) b2b_cnt++;
    last_we = imem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request and complete the handshake; returns just after the edge.
  task automatic send(input logic [2:0] kind, input logic [2:0] f3, input logic f7b5,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [20:0] imm);
    int waited;
    @(negedge clk);
    req_kind     = kind;
    req_funct3   = f3;
    req_funct7b5 = f7b5;
    req_rd       = rd;
    req_rs1      = rs1;
    req_rs2      = rs2;
    req_imm      = imm;
    req_valid    = 1'b1;
    waited       = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  // Legal request: expect one write at the given address, then count step.
  task automatic send_write(input string tag, input logic [2:0] kind, input logic [2:0] f3,
                            input logic f7b5, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [20:0] imm,
                            input logic [31:0] exp_addr, input logic [31:0] exp_word,
                            input logic [31:0] exp_cnt);
    send(kind, f3, f7b5, rd, rs1, rs2, imm);
    check({tag, "_we"},    32'(imem_we), 32'd1);
    check({tag, "_addr"},  32'(imem_addr), exp_addr);
    check({tag, "_wdata"}, imem_wdata, exp_word);
    check({tag, "_rdy0"},  32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_we_off"}, 32'(imem_we), 32'd0);
    check({tag, "_count"},  32'(count), exp_cnt);
  endtask

  // Illegal request: accepted, nothing written, err raised, count held.
  task automatic send_illegal(input string tag, input logic [2:0] kind,
                              input logic [20:0] imm, input logic [31:0] exp_cnt);
    send(kind, 3'd0, 1'b0, 5'd1, 5'd1, 5'd2, imm);
    check({tag, "_we"},    32'(imem_we), 32'd0);
    check({tag, "_err"},   32'(err), 32'd1);
    check({tag, "_count"}, 32'(count), exp_cnt);
    check({tag, "_rdy"},   32'(req_ready), 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    wr_cnt       = 0;
    b2b_cnt      = 0;
    last_we      = 1'b0;
    rst_n        = 1'b0;
    start        = 1'b0;
    req_valid    = 1'b0;
    req_kind     = 3'd0;
    req_funct3   = 3'd0;
    req_funct7b5 = 1'b0;
    req_rd       = 5'd0;
    req_rs1      = 5'd0;
    req_rs2      = 5'd0;
    req_imm      = 21'd0;

    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_we",    32'(imem_we), 32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full",  32'(full), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // LW x5, 8(x2)
    send_write("lw", 3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8, 32'd0, 32'h00812283, 32'd1);
    // SUB x3, x1, x2
    send_write("sub", 3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 32'd1, 32'h402081B3, 32'd2);
    // Odd branch offset and illegal kind: dropped
    send_illegal("beq_odd", 3'd3, 21'd3, 32'd2);
    send_illegal("kind6",   3'd6, 21'd0, 32'd2);
    // BEQ x1, x2, -4 at the un-advanced address
    send_write("beq", 3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 32'd2, 32'hFE208EE3, 32'd3);
    // JAL x1, 8 fills the last word
    send_write("jal", 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8, 32'd3, 32'h008000EF, 32'd4);
    check("full_set",   32'(full), 32'd1);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_err",   32'(err), 32'd1);
    @(negedge clk);
    check("full_hold",  32'(full), 32'd1);

    // Restart
    start = 1'b1;
    #1;
    check("start_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_full",  32'(full), 32'd0);
    check("start_err",   32'(err), 32'd0);
    check("start_count", 32'(count), 32'd0);
    check("start_addr",  32'(imem_addr), 32'd0);

    // SW x5, 12(x2) at base
    send_write("sw", 3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 21'd12, 32'd0, 32'h00512623, 32'd1);
    // ADDI x1, x0, -1
    send_write("addi", 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, 32'd1, 32'hFFF00093, 32'd2);
    // LW offset 2048 is out of range
    send_illegal("lw_range", 3'd0, 21'h000800, 32'd2);

    // Reset in the middle of a write cycle
    send(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8);
    check("mid_we_before", 32'(imem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_we",    32'(imem_we), 32'd0);
    check("mid_addr",  32'(imem_addr), 32'd0);
    check("mid_wdata", imem_wdata, 32'h0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_err",   32'(err), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_ready", 32'(req_ready), 32'd1);
    check("post_count", 32'(count), 32'd0);
    check("write_total", 32'(wr_cnt), 32'd6);
    check("no_b2b_we",   32'(b2b_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
